// File: rtl/vend_fsm_param_if.sv
`default_nettype none
// ============================================================================
// Module   : vend_fsm_param_if
// Purpose  : Bundles the coin / select / cancel requests and the actuator and
//            status returns of the vending controller into one bus.
//            master : coin-acceptor / keypad side (drives requests)
//            slave  : the vending controller (drives actuators and status)
// Ports    : coin_valid, coin_value, select_valid, select_id, cancel (requests)
//            dispense, change_pulse, credit, coin_reject, insufficient,
//            sel_error, busy (returns)
//            restock / sold_out exist only when VEND_STOCK_EN is defined.
// Macro    : VEND_STOCK_EN
// Revision : 1.0 - initial release
// ============================================================================
interface vend_fsm_param_if #(
    parameter int NUM_PROD = 4,
    parameter int SEL_W    = 2,
    parameter int CREDIT_W = 8
);
    logic                coin_valid;
    logic [CREDIT_W-1:0] coin_value;
    logic                select_valid;
    logic [SEL_W-1:0]    select_id;
    logic                cancel;
    logic [NUM_PROD-1:0] dispense;
    logic                change_pulse;
    logic [CREDIT_W-1:0] credit;
    logic                coin_reject;
    logic                insufficient;
    logic                sel_error;
    logic                busy;
`ifdef VEND_STOCK_EN
    logic                restock;
    logic                sold_out;
`endif

    modport master (
`ifdef VEND_STOCK_EN
        output restock,
        input  sold_out,
`endif
        output coin_valid, coin_value, select_valid, select_id, cancel,
        input  dispense, change_pulse, credit, coin_reject, insufficient,
        input  sel_error, busy
    );

    modport slave (
`ifdef VEND_STOCK_EN
        input  restock,
        output sold_out,
`endif
        input  coin_valid, coin_value, select_valid, select_id, cancel,
        output dispense, change_pulse, credit, coin_reject, insufficient,
        output sel_error, busy
    );
endinterface
`default_nettype wire

// File: rtl/vend_fsm_param.sv
`default_nettype none
// ============================================================================
// Module   : vend_fsm_param
// Purpose  : Parametrised vending controller. Accumulates coin credit, sells
//            one of NUM_PROD products at per-product prices, refunds on
//            cancel and returns change as a train of CHANGE_UNIT pulses.
// Ports    : clock  - rising-edge clock
//            reset  - asynchronous active-low reset
//            bus    - vend_fsm_param_if.slave (requests in, actuators out)
// Macro    : VEND_STOCK_EN - adds per-product stock counters, the sold_out
//            pulse and the restock request.
// Revision : 1.0 - initial release
// ============================================================================
module vend_fsm_param #(
    parameter int                            NUM_PROD    = 4,
    parameter int                            SEL_W       = 2,
    parameter int                            CREDIT_W    = 8,
    parameter int                            MAX_CREDIT  = 200,
    parameter int                            CHANGE_UNIT = 5,
    parameter int                            MAX_COIN    = 20,
    parameter logic [NUM_PROD*CREDIT_W-1:0]  PRICE_LIST  = {8'd25, 8'd15, 8'd10, 8'd5},
    parameter int                            STOCK_INIT  = 8
) (
    input  wire logic       clock,
    input  wire logic       reset,
    vend_fsm_param_if.slave bus
);

    localparam logic [CREDIT_W-1:0] c_unit       = CREDIT_W'(CHANGE_UNIT);
    localparam logic [CREDIT_W-1:0] c_max_coin   = CREDIT_W'(MAX_COIN);
    localparam logic [CREDIT_W:0]   c_max_credit = (CREDIT_W + 1)'(MAX_CREDIT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_VEND   = 2'd2,
        S_CHANGE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] vend_price_q, vend_price_d;
    logic [NUM_PROD-1:0] dispense_q, dispense_d;
    logic                change_pulse_q, change_pulse_d;
    logic                coin_reject_q, coin_reject_d;
    logic                insufficient_q, insufficient_d;
    logic                sel_error_q, sel_error_d;
    logic                busy_q, busy_d;

    // Price table unpacked from the flat parameter; product 0 is the LSB slice.
    logic [CREDIT_W-1:0] price_tab [NUM_PROD];

    for (genvar gi = 0; gi < NUM_PROD; gi++) begin : g_price
        assign price_tab[gi] = PRICE_LIST[gi*CREDIT_W +: CREDIT_W];
    end

    // Decode of the requested product. An out-of-range id matches no entry,
    // which leaves id_ok low and the price at zero.
    logic [CREDIT_W-1:0] sel_price;
    logic [NUM_PROD-1:0] sel_onehot;
    logic                id_ok;

    always_comb begin
        sel_price  = '0;
        sel_onehot = '0;
        id_ok      = 1'b0;
        for (int i = 0; i < NUM_PROD; i++) begin
            if (bus.select_id == SEL_W'(i)) begin
                sel_price     = price_tab[i];
                sel_onehot[i] = 1'b1;
                id_ok         = 1'b1;
            end
        end
    end

    // Coin qualification. The sum is one bit wider than credit so that an
    // overflowing coin compares as too large instead of wrapping.
    logic [CREDIT_W:0] coin_sum;
    logic              coin_ok;

    assign coin_sum = {1'b0, credit_q} + {1'b0, bus.coin_value};
    assign coin_ok  = (bus.coin_value != '0)
                   && ((bus.coin_value % c_unit) == '0)
                   && (bus.coin_value <= c_max_coin)
                   && (coin_sum <= c_max_credit);

`ifdef VEND_STOCK_EN
    localparam int                   c_stock_w    = (STOCK_INIT < 1) ? 1 : $clog2(STOCK_INIT + 1);
    localparam logic [c_stock_w-1:0] c_stock_init = c_stock_w'(STOCK_INIT);

    logic [c_stock_w-1:0] stock_q [NUM_PROD];
    logic [c_stock_w-1:0] stock_d [NUM_PROD];
    logic [c_stock_w-1:0] stock_sel;
    logic                 sold_out_q, sold_out_d;

    always_comb begin
        stock_sel = '0;
        for (int i = 0; i < NUM_PROD; i++) begin
            if (sel_onehot[i]) begin
                stock_sel = stock_q[i];
            end
        end
    end
`else
    logic unused_stock_init;
    assign unused_stock_init = (STOCK_INIT > 0);
`endif

    // High when a cancel or a select is accepted this cycle; a coin arriving
    // alongside one of those is refused.
    logic req_taken;

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        vend_price_d   = vend_price_q;
        dispense_d     = '0;
        change_pulse_d = 1'b0;
        coin_reject_d  = 1'b0;
        insufficient_d = 1'b0;
        sel_error_d    = 1'b0;
        req_taken      = 1'b0;
`ifdef VEND_STOCK_EN
        sold_out_d     = 1'b0;
        stock_d        = stock_q;
`endif

        case (state_q)
            S_IDLE, S_CREDIT: begin
                if (bus.cancel && (state_q == S_CREDIT)) begin
                    // Refund starts with the first pulse in the next cycle.
                    state_d        = S_CHANGE;
                    change_pulse_d = 1'b1;
                    req_taken      = 1'b1;
                end else if (bus.select_valid) begin
                    if (!id_ok) begin
                        sel_error_d = 1'b1;
`ifdef VEND_STOCK_EN
                    end else if (stock_sel == '0) begin
                        sold_out_d = 1'b1;
`endif
                    end else if (sel_price > credit_q) begin
                        insufficient_d = 1'b1;
                    end else begin
                        state_d      = S_VEND;
                        vend_price_d = sel_price;
                        dispense_d   = sel_onehot;
                        req_taken    = 1'b1;
                    end
                end

                if (bus.coin_valid) begin
                    if (!req_taken && coin_ok) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = S_CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end

`ifdef VEND_STOCK_EN
                if (bus.restock) begin
                    for (int i = 0; i < NUM_PROD; i++) begin
                        stock_d[i] = c_stock_init;
                    end
                end
`endif
            end

            S_VEND: begin
                coin_reject_d = bus.coin_valid;
                credit_d      = credit_q - vend_price_q;
                if (credit_d != '0) begin
                    state_d        = S_CHANGE;
                    change_pulse_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
`ifdef VEND_STOCK_EN
                // dispense_q still holds the one-hot of the product being sold.
                for (int i = 0; i < NUM_PROD; i++) begin
                    if (dispense_q[i] && (stock_q[i] != '0)) begin
                        stock_d[i] = stock_q[i] - 1'b1;
                    end
                end
`endif
            end

            S_CHANGE: begin
                coin_reject_d = bus.coin_valid;
                // The pulse on the output this cycle pays out one unit.
                if (credit_q <= c_unit) begin
                    credit_d = '0;
                    state_d  = S_IDLE;
                end else begin
                    credit_d       = credit_q - c_unit;
                    change_pulse_d = 1'b1;
                end
            end

            default: begin
                state_d  = S_IDLE;
                credit_d = '0;
            end
        endcase

        busy_d = (state_d == S_VEND) || (state_d == S_CHANGE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            vend_price_q   <= '0;
            dispense_q     <= '0;
            change_pulse_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            insufficient_q <= 1'b0;
            sel_error_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            vend_price_q   <= vend_price_d;
            dispense_q     <= dispense_d;
            change_pulse_q <= change_pulse_d;
            coin_reject_q  <= coin_reject_d;
            insufficient_q <= insufficient_d;
            sel_error_q    <= sel_error_d;
            busy_q         <= busy_d;
        end
    end

`ifdef VEND_STOCK_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sold_out_q <= 1'b0;
            for (int i = 0; i < NUM_PROD; i++) begin
                stock_q[i] <= c_stock_init;
            end
        end else begin
            sold_out_q <= sold_out_d;
            for (int i = 0; i < NUM_PROD; i++) begin
                stock_q[i] <= stock_d[i];
            end
        end
    end

    assign bus.sold_out = sold_out_q;
`endif

    assign bus.dispense     = dispense_q;
    assign bus.change_pulse = change_pulse_q;
    assign bus.credit       = credit_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.insufficient = insufficient_q;
    assign bus.sel_error    = sel_error_q;
    assign bus.busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_vend_fsm_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_fsm_param
// Purpose  : Self-checking bench for vend_fsm_param. Two controllers share one
//            stimulus stream: the default 4-product build and a 3-product
//            build with a stock of one per product. A schedule-based model
//            predicts every output on every cycle; directed checks pin key
//            values by hand.
// Macro    : VEND_STOCK_EN (sold-out / restock checks)
// Revision : 1.0 - initial release
// ============================================================================
module tb_vend_fsm_param;

`ifdef VEND_STOCK_EN
    localparam bit STOCK_EN = 1'b1;
`else
    localparam bit STOCK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_valid = 1'b0;
    logic [7:0] coin_value = '0;
    logic       select_valid = 1'b0;
    logic [1:0] select_id = '0;
    logic       cancel = 1'b0;
    logic       restock = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vend_fsm_param_if #(.NUM_PROD(4), .SEL_W(2), .CREDIT_W(8)) if0 ();
    vend_fsm_param_if #(.NUM_PROD(3), .SEL_W(2), .CREDIT_W(8)) if1 ();

    assign if0.coin_valid   = coin_valid;
    assign if0.coin_value   = coin_value;
    assign if0.select_valid = select_valid;
    assign if0.select_id    = select_id;
    assign if0.cancel       = cancel;
    assign if1.coin_valid   = coin_valid;
    assign if1.coin_value   = coin_value;
    assign if1.select_valid = select_valid;
    assign if1.select_id    = select_id;
    assign if1.cancel       = cancel;

    logic so0, so1;
`ifdef VEND_STOCK_EN
    assign if0.restock = restock;
    assign if1.restock = restock;
    assign so0 = if0.sold_out;
    assign so1 = if1.sold_out;
`else
    assign so0 = 1'b0;
    assign so1 = 1'b0;
`endif

    vend_fsm_param u_dut0 (
        .clock (clk),
        .reset (rst_n),
        .bus   (if0)
    );

    vend_fsm_param #(
        .NUM_PROD   (3),
        .PRICE_LIST ({8'd15, 8'd10, 8'd5}),
        .STOCK_INIT (1)
    ) u_dut1 (
        .clock (clk),
        .reset (rst_n),
        .bus   (if1)
    );

    // ------------------------------------------------------------------
    // Model: while a controller is idle its wallet follows the coin/select
    // rules directly; an accepted sale or refund is expanded into a list
    // of future cycles (credit shown, product dispensed, change pulse) that
    // is then played back one entry per cycle.
    // ------------------------------------------------------------------
    int np[2]         = '{4, 3};
    int price[2][4]   = '{'{5, 10, 15, 25}, '{5, 10, 15, 0}};
    int stock_init[2] = '{8, 1};

    int m_wallet[2];
    int m_stock[2][4];
    int s_credit[2][64];
    int s_disp[2][64];
    bit s_pulse[2][64];
    int s_len[2];
    int s_pos[2];
    logic [17:0] e_vec[2] = '{'0, '0};

    function automatic bit coin_ok(input int v, input int w);
        return (v != 0) && (v % 5 == 0) && (v <= 20) && (w + v <= 200);
    endfunction

    task automatic push(input int d, input int cr, input int id, input bit pl);
        s_credit[d][s_len[d]] = cr;
        s_disp[d][s_len[d]]   = id;
        s_pulse[d][s_len[d]]  = pl;
        s_len[d]++;
    endtask

    task automatic push_change(input int d, input int r);
        for (int j = 0; j < r / 5; j++) push(d, r - 5 * j, -1, 1'b1);
    endtask

    task automatic model_step(input int d);
        logic [3:0] disp;
        bit pulse, rej, ins, sel, so, busy, taken, accept;
        int cr, w, id;
        disp = '0; pulse = 0; rej = 0; ins = 0; sel = 0; so = 0; busy = 0;
        taken = 0; accept = 0; cr = 0; id = int'(select_id);
        if (s_pos[d] < s_len[d]) begin
            cr    = s_credit[d][s_pos[d]];
            if (s_disp[d][s_pos[d]] >= 0) disp = 4'b0001 << s_disp[d][s_pos[d]];
            pulse = s_pulse[d][s_pos[d]];
            busy  = 1'b1;
            rej   = coin_valid;
            s_pos[d]++;
        end else begin
            w = m_wallet[d];
            s_len[d] = 0;
            s_pos[d] = 0;
            if (cancel && w > 0) begin
                push_change(d, w);
                taken = 1;
            end else if (select_valid) begin
                if (id >= np[d]) sel = 1;
                else if (STOCK_EN && m_stock[d][id] == 0) so = 1;
                else if (price[d][id] > w) ins = 1;
                else begin
                    push(d, w, id, 1'b0);
                    push_change(d, w - price[d][id]);
                    taken = 1;
                    accept = 1;
                end
            end
            if (STOCK_EN && restock) for (int k = 0; k < 4; k++) m_stock[d][k] = stock_init[d];
            if (STOCK_EN && accept) m_stock[d][id]--;
            if (coin_valid) begin
                if (!taken && coin_ok(int'(coin_value), w)) m_wallet[d] = w + int'(coin_value);
                else rej = 1;
            end
            if (taken) begin
                m_wallet[d] = 0;
                cr    = s_credit[d][0];
                if (s_disp[d][0] >= 0) disp = 4'b0001 << s_disp[d][0];
                pulse = s_pulse[d][0];
                busy  = 1'b1;
                s_pos[d] = 1;
            end else begin
                cr = m_wallet[d];
            end
        end
        e_vec[d] = {disp, pulse, 8'(cr), rej, ins, sel, busy, so};
    endtask

    // Compare process: outputs are checked on the falling edge, then the
    // model advances using the inputs that the next rising edge will see.
    initial begin : p_compare
        logic [17:0] act [2];
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int d = 0; d < 2; d++) begin
                    m_wallet[d] = 0; s_len[d] = 0; s_pos[d] = 0; e_vec[d] = '0;
                    for (int k = 0; k < 4; k++) m_stock[d][k] = stock_init[d];
                end
            end
            act[0] = {if0.dispense, if0.change_pulse, if0.credit, if0.coin_reject,
                      if0.insufficient, if0.sel_error, if0.busy, so0};
            act[1] = {1'b0, if1.dispense, if1.change_pulse, if1.credit, if1.coin_reject,
                      if1.insufficient, if1.sel_error, if1.busy, so1};
            for (int d = 0; d < 2; d++) begin
                n_vec++;
                if (act[d] !== e_vec[d]) begin
                    n_err++;
                    $display("FAIL cycle_model dut%0d t=%0t: got %b expected %b (disp,pulse,credit,rej,ins,sel,busy,sold)",
                             d, $time, act[d], e_vec[d]);
                end
            end
            if (rst_n) for (int d = 0; d < 2; d++) model_step(d);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
        coin_valid = 1'b0; coin_value = '0; select_valid = 1'b0;
        select_id = '0; cancel = 1'b0; restock = 1'b0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic coin(input int v);
        coin_valid = 1'b1; coin_value = 8'(v);
        tick();
    endtask

    task automatic sel(input int id);
        select_valid = 1'b1; select_id = 2'(id);
        tick();
    endtask

    // Refund everything and wait (bounded) until both controllers are idle.
    task automatic drain();
        int k;
        cancel = 1'b1;
        tick();
        k = 0;
        while ((if0.busy || if1.busy) && k < 200) begin
            tick();
            k++;
        end
        chk("drain_idle", int'(if0.busy || if1.busy), 0);
    endtask

    initial begin : p_stim
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("reset_credit", int'(if0.credit), 0);
        chk("reset_busy", int'(if0.busy), 0);
        chk("reset_disp", int'(if0.dispense), 0);

        // Exact payment: 5+10+10 buys product 3 at 25, no change.
        coin(5); coin(10); coin(10);
        chk("t1_credit", int'(if0.credit), 25);
        sel(3);
        chk("t1_disp", int'(if0.dispense), 8);
        chk("t1_vend_credit", int'(if0.credit), 25);
        chk("t1_busy", int'(if0.busy), 1);
        chk("t1_dut1_selerr", int'(if1.sel_error), 1);
        tick();
        chk("t1_after_credit", int'(if0.credit), 0);
        chk("t1_after_pulse", int'(if0.change_pulse), 0);
        chk("t1_after_busy", int'(if0.busy), 0);
        drain();

        // 20 in, product 0 at 5: three change pulses 15 -> 10 -> 5 -> 0.
        coin(20);
        sel(0);
        chk("t2_disp", int'(if0.dispense), 1);
        chk("t2_vend_credit", int'(if0.credit), 20);
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("t2_pulse", int'(if0.change_pulse), 1);
            chk("t2_credit", int'(if0.credit), 15 - 5 * j);
            chk("t2_busy", int'(if0.busy), 1);
        end
        tick();
        chk("t2_end_pulse", int'(if0.change_pulse), 0);
        chk("t2_end_busy", int'(if0.busy), 0);
        chk("t2_end_credit", int'(if0.credit), 0);
        drain();

        // Too little for product 2, then cancel refunds 10 as two pulses.
        coin(10);
        sel(2);
        chk("t3_insuff", int'(if0.insufficient), 1);
        chk("t3_credit", int'(if0.credit), 10);
        cancel = 1'b1;
        tick();
        chk("t3_cancel_pulse", int'(if0.change_pulse), 1);
        chk("t3_cancel_credit", int'(if0.credit), 10);
        tick();
        chk("t3_pulse2_credit", int'(if0.credit), 5);
        tick();
        chk("t3_end_credit", int'(if0.credit), 0);
        chk("t3_end_busy", int'(if0.busy), 0);
        drain();

        // Coin rejection rules and the credit ceiling.
        sel(1);
        chk("t4_idle_insuff", int'(if0.insufficient), 1);
        coin(7);
        chk("t4_rej7", int'(if0.coin_reject), 1);
        coin(40);
        chk("t4_rej40", int'(if0.coin_reject), 1);
        coin(0);
        chk("t4_rej0", int'(if0.coin_reject), 1);
        chk("t4_credit0", int'(if0.credit), 0);
        for (int j = 0; j < 9; j++) coin(20);
        coin(10);
        chk("t4_credit190", int'(if0.credit), 190);
        coin(20);
        chk("t4_rej_ceiling", int'(if0.coin_reject), 1);
        chk("t4_credit_hold", int'(if0.credit), 190);
        coin(10);
        chk("t4_accept_200", int'(if0.coin_reject), 0);
        chk("t4_credit200", int'(if0.credit), 200);
        coin(5);
        chk("t4_rej_over", int'(if0.coin_reject), 1);
        sel(3);
        chk("t4_dut1_selerr", int'(if1.sel_error), 1);
        chk("t4_dut1_credit", int'(if1.credit), 200);
        drain();

        // Coin beside an accepted select, and coin during change.
        coin(10);
        coin_valid = 1'b1; coin_value = 8'd5;
        sel(1);
        chk("t5_same_rej", int'(if0.coin_reject), 1);
        chk("t5_same_disp", int'(if0.dispense), 2);
        chk("t5_same_credit", int'(if0.credit), 10);
        tick();
        chk("t5_after_credit", int'(if0.credit), 0);
        coin(20);
        sel(0);
        tick();
        chk("t5_chg_credit", int'(if0.credit), 15);
        coin(10);
        chk("t5_chg_rej", int'(if0.coin_reject), 1);
        chk("t5_chg_credit2", int'(if0.credit), 10);
        drain();

        // Asynchronous reset in the middle of a refund.
        coin(10);
        cancel = 1'b1;
        tick();
        chk("t6_pre_pulse", int'(if0.change_pulse), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_credit", int'(if0.credit), 0);
        chk("t6_rst_pulse", int'(if0.change_pulse), 0);
        chk("t6_rst_busy", int'(if0.busy), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_post_credit", int'(if0.credit), 0);

        // Stock on the one-per-product controller, product 2.
        coin(20);
        sel(2);
        chk("t7_first_disp", int'(if1.dispense), 4);
        drain();
        coin(20);
        sel(2);
`ifdef VEND_STOCK_EN
        chk("t7_soldout", int'(if1.sold_out), 1);
        chk("t7_soldout_busy", int'(if1.busy), 0);
        chk("t7_soldout_credit", int'(if1.credit), 20);
`else
        chk("t7_unlimited_disp", int'(if1.dispense), 4);
`endif
        drain();
        restock = 1'b1;
        coin(20);
        sel(2);
        chk("t7_restock_disp", int'(if1.dispense), 4);
        drain();

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/vend_fsm_param.md
Name: vend_fsm_param

Overview:
- Parametrised vending controller: NUM_PROD products with per-product prices, multi-coin credit accumulation, cancel, and serial change return.
- Credit is held in the block across cycles. Purchases and change are issued as registered single-cycle pulses.
- Sits between the coin-acceptor front end and the product/change actuators in the vending subsystem.

Parameters:
- NUM_PROD, 4, number of products.
- SEL_W, 2, width of select_id; must satisfy 2**SEL_W >= NUM_PROD.
- CREDIT_W, 8, width of credit and coin values.
- MAX_CREDIT, 200, credit ceiling. A coin that would exceed it is rejected.
- CHANGE_UNIT, 5, value of one change pulse. All prices and accepted coins are multiples of it.
- MAX_COIN, 20, largest accepted coin value.
- PRICE_LIST, {8'd25,8'd15,8'd10,8'd5}, packed NUM_PROD*CREDIT_W prices. Product 0 is in the LSB slice.
- STOCK_INIT, 8, initial per-product stock. Used only with VEND_STOCK_EN.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- coin_valid  in  1  coin present this cycle.
- coin_value  in  CREDIT_W  coin denomination.
- select_valid  in  1  purchase request.
- select_id  in  SEL_W  product index.
- cancel  in  1  refund all credit.
- dispense  out  NUM_PROD  one-hot purchase pulse.
- change_pulse  out  1  one CHANGE_UNIT returned.
- credit  out  CREDIT_W  current credit.
- coin_reject  out  1  coin refused (pulse).
- insufficient  out  1  select refused: low credit (pulse).
- sel_error  out  1  select_id >= NUM_PROD (pulse).
- busy  out  1  high in VEND or CHANGE.
- sold_out  out  1  present only with VEND_STOCK_EN.
- restock  in  1  present only with VEND_STOCK_EN.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, credit=0.
  - All pulse outputs 0, busy=0.
  - Stock counters = STOCK_INIT.
- States: IDLE (credit==0), CREDIT (credit>0), VEND, CHANGE.
- Coin acceptance (IDLE/CREDIT only):
  - Accepted if coin_value !=0, coin_value %CHANGE_UNIT==0, coin_value <=MAX_COIN, and credit+coin_value <=MAX_CREDIT.
  - Compute the sum at CREDIT_W+1 bits; no wrap.
  - Accepted coin: credit updates at the next edge; IDLE->CREDIT.
  - Otherwise coin_reject=1 for one cycle and credit is unchanged.
- Priority in IDLE/CREDIT: cancel > select > coin.
  - A coin arriving in the same cycle as an accepted cancel or accepted select is rejected.
  - A coin arriving with a refused select is processed normally.
- Select:
  - Evaluated against the registered credit (not including a same-cycle coin).
  - select_id >= NUM_PROD: sel_error pulse next cycle, no state change.
  - price > credit: insufficient pulse next cycle, no state change.
  - Otherwise: latch select_id and go to VEND.
- VEND (exactly 1 cycle):
  - dispense[id]=1.
  - credit <= credit-price at the end of the cycle.
  - Next state CHANGE if the remainder >0, else IDLE.
- CHANGE:
  - change_pulse=1 every cycle.
  - credit -= CHANGE_UNIT per cycle.
  - Leave to IDLE in the cycle after the pulse that brings credit to 0.
  - Change for credit C takes C/CHANGE_UNIT consecutive cycles.
- Cancel:
  - In CREDIT: go straight to CHANGE.
  - In IDLE: no effect.
  - In VEND/CHANGE: ignored.
- In VEND/CHANGE: every coin is rejected; select and cancel are ignored (no error pulses).
- Select in IDLE (credit 0) with a valid id and nonzero price gives insufficient.
- Latency: accepted select at edge t gives dispense high in cycle t+1; the first change_pulse is in cycle t+2.
- Reset asserted mid-VEND or mid-CHANGE: credit is lost (zeroed) and outputs drop asynchronously.
- All outputs are registered.

Optional Feature:
- Macro VEND_STOCK_EN.
- Defined:
  - Per-product stock counters, width ceil(log2(STOCK_INIT+1)), decremented in VEND.
  - A select of a product with stock 0 gives a sold_out pulse next cycle, no state change. This check takes priority over insufficient.
  - restock=1 in IDLE/CREDIT reloads all counters to STOCK_INIT.
  - sold_out and restock ports exist.
- Undefined:
  - Unlimited stock; no counters.
  - sold_out and restock ports are absent.

Test Plan:
- Coins 5, 10, 10 then select 3 (price 25) -> dispense=4'b1000 one cycle, credit 25->0, no change_pulse, return to IDLE.
- Coin 20, select 0 (price 5) -> dispense[0], then 3 consecutive change_pulse, credit 15->10->5->0, busy high for 4 cycles.
- Coin 10, select 2 (price 15) -> insufficient pulse, credit stays 10. Then cancel -> 2 change_pulse, credit 0.
- Coin 7, coin 40, and coin 20 when credit=190 -> coin_reject each time, credit unchanged. select_id=3 with NUM_PROD=3 -> sel_error.
- Coin 5 in the same cycle as an accepted select; coin during CHANGE -> coin_reject in both cases, credit unaffected.
- Reset pulled low mid-CHANGE with credit 10 -> credit=0, change_pulse=0 immediately. With VEND_STOCK_EN and STOCK_INIT=1, a second purchase of the same product -> sold_out; restock then allows the purchase.
